// File: rtl/mem_resp_stage.sv
// MEM stage for a split-transaction data memory: in-order response FIFO, flush draining, load extraction.
// Build option MEM_LOAD_FWD_EN: forward extracted load data onto the bypass bus once the response is held.
module mem_resp_stage #(
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_result,
  input  logic        in_rf_we,
  input  logic [4:0]  in_rf_waddr,
  input  logic        in_mem_req,
  input  logic        in_res_from_mem,
  input  logic [4:0]  in_ld_ctrl,
  input  logic        req_accepted,
  output logic        req_allow,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_result,
  output logic [31:0] out_mem_result,
  output logic        out_rf_we,
  output logic        out_res_from_mem,
  output logic [4:0]  out_rf_waddr,
  output logic        byp_we,
  output logic [4:0]  byp_waddr,
  output logic        byp_data_ok,
  output logic [31:0] byp_data
);

  // One spare bit: a flush may see MAX_OUT outstanding plus one accepted that same cycle.
  localparam int IW = CNT_W + 1;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [IW:0]   MAX_CREDIT = (IW + 1)'(MAX_OUT);
  localparam logic [PW-1:0] LAST_PTR   = PW'(MAX_OUT - 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    logic [PW-1:0] nxt;
    if (ptr == LAST_PTR) nxt = {PW{1'b0}};
    else                 nxt = ptr + PW'(1);
    return nxt;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [4:0] ctrl);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (ctrl)
      5'b10000: res = word;
      5'b01000: res = {{24{b[7]}}, b};
      5'b00100: res = {24'h000000, b};
      5'b00010: res = {{16{h[15]}}, h};
      5'b00001: res = {16'h0000, h};
      default:  res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  logic          valid_r, rf_we_r, mem_req_r, res_from_mem_r;
  logic [31:0]   pc_r, result_r;
  logic [4:0]    rf_waddr_r, ld_ctrl_r;
  logic [IW-1:0] inflight_r, drop_r, fifo_cnt_r;
  logic [IW-1:0] inflight_nxt_s, drop_nxt_s, fifo_cnt_nxt_s;
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [31:0]   fifo_mem_r [MAX_OUT];
  logic          dok_s, drop_s, push_s, pop_s, fifo_ne_s, ready_go_s, retire_s, capture_s;
  logic [IW:0]   credit_s;
  logic [31:0]   head_s, mem_result_s;

  assign fifo_ne_s  = (fifo_cnt_r != {IW{1'b0}});
  assign ready_go_s = ~mem_req_r | fifo_ne_s;
  assign out_valid  = valid_r & ready_go_s;
  assign in_ready   = ~valid_r | (ready_go_s & out_ready);
  assign retire_s   = out_valid & out_ready & ~flush;
  assign capture_s  = in_valid & in_ready & ~flush;
  // A strobe with nothing outstanding is a protocol error and is ignored.
  assign dok_s      = data_sram_data_ok & (inflight_r != {IW{1'b0}});
  assign drop_s     = dok_s & (drop_r != {IW{1'b0}});
  assign push_s     = dok_s & ~drop_s & ~flush;
  assign pop_s      = retire_s & mem_req_r;
  assign credit_s   = {1'b0, inflight_r} + {1'b0, fifo_cnt_r};
  assign req_allow  = (credit_s < MAX_CREDIT) & ~flush;

  assign head_s       = fifo_mem_r[rd_ptr_r];
  assign mem_result_s = fifo_ne_s ? load_extract(head_s, result_r[1:0], ld_ctrl_r) : 32'h0000_0000;

  assign out_pc           = pc_r;
  assign out_result       = result_r;
  assign out_mem_result   = mem_result_s;
  assign out_rf_we        = rf_we_r;
  assign out_res_from_mem = res_from_mem_r;
  assign out_rf_waddr     = rf_waddr_r;
  assign byp_we           = valid_r & rf_we_r;
  assign byp_waddr        = rf_waddr_r;

`ifdef MEM_LOAD_FWD_EN
  assign byp_data_ok = valid_r & (~res_from_mem_r | fifo_ne_s);
  assign byp_data    = (res_from_mem_r & fifo_ne_s) ? mem_result_s : result_r;
`else
  assign byp_data_ok = valid_r & ~res_from_mem_r;
  assign byp_data    = result_r;
`endif

  // Counter next-state; flush turns every outstanding request into one to drop.
  always_comb begin
    inflight_nxt_s = inflight_r + IW'(req_accepted) - IW'(dok_s);
    drop_nxt_s     = drop_r;
    fifo_cnt_nxt_s = fifo_cnt_r;
    if (flush) begin
      drop_nxt_s     = inflight_nxt_s;
      fifo_cnt_nxt_s = {IW{1'b0}};
    end else begin
      drop_nxt_s     = drop_r - IW'(drop_s);
      fifo_cnt_nxt_s = fifo_cnt_r + IW'(push_s) - IW'(pop_s);
    end
  end

  // Counter and FIFO pointer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inflight_r <= {IW{1'b0}};
      drop_r     <= {IW{1'b0}};
      fifo_cnt_r <= {IW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
    end else begin
      inflight_r <= inflight_nxt_s;
      drop_r     <= drop_nxt_s;
      fifo_cnt_r <= fifo_cnt_nxt_s;
      if (flush) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
        if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

  // Response FIFO storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_OUT; i++) fifo_mem_r[i] <= 32'h0000_0000;
    end else if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= data_sram_rdata;
    end
  end

  // Stage register: flush beats capture beats retire.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_r        <= 1'b0;
      pc_r           <= 32'h0000_0000;
      result_r       <= 32'h0000_0000;
      rf_we_r        <= 1'b0;
      rf_waddr_r     <= 5'd0;
      mem_req_r      <= 1'b0;
      res_from_mem_r <= 1'b0;
      ld_ctrl_r      <= 5'd0;
    end else begin
      if (flush)          valid_r <= 1'b0;
      else if (capture_s) valid_r <= 1'b1;
      else if (retire_s)  valid_r <= 1'b0;
      if (capture_s) begin
        pc_r           <= in_pc;
        result_r       <= in_result;
        rf_we_r        <= in_rf_we;
        rf_waddr_r     <= in_rf_waddr;
        mem_req_r      <= in_mem_req;
        res_from_mem_r <= in_res_from_mem;
        ld_ctrl_r      <= in_ld_ctrl;
      end
    end
  end

endmodule
